// File: rtl/alu_result_serializer.sv
// Buffers 16-bit ALU results in a small FIFO and streams each one out low byte first over a valid/ready byte port.
// Optional: define ALU_SER_CHECKSUM_EN to append an XOR checksum byte (lo ^ hi) after every result.
module alu_result_serializer #(
    parameter int ALU_OUT_WIDTH = 16,
    parameter int BYTE_WIDTH    = 8,
    parameter int DEPTH         = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [ALU_OUT_WIDTH-1:0] alu_out_i,
    input  logic                     out_valid_i,
    output logic [BYTE_WIDTH-1:0]    tx_data_o,
    output logic                     tx_valid_o,
    input  logic                     tx_ready_i,
    output logic [$clog2(DEPTH):0]   fill_o,
    output logic                     busy_o,
    output logic                     overflow_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int FW = AW + 1;

    typedef enum logic [1:0] {
        IDLE,
        SEND_LO,
        SEND_HI
`ifdef ALU_SER_CHECKSUM_EN
        , SEND_CHK
`endif
    } state_e;

    state_e                   state_q, state_d;
    logic [ALU_OUT_WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]            wrPtr_q, rdPtr_q;
    logic [FW-1:0]            fill_q, fill_d;
    logic [ALU_OUT_WIDTH-1:0] word_q, word_d;
    logic [BYTE_WIDTH-1:0]    txData_q, txData_d;
    logic                     txValid_q, txValid_d;
    logic                     overflow_q;

    logic                     handshake;
    logic                     packetDone;
    logic                     pop;
    logic                     push;
    logic [ALU_OUT_WIDTH-1:0] headWord;

    assign handshake = txValid_q & tx_ready_i;
    assign headWord  = mem_q[rdPtr_q];

    always_comb begin
        state_d    = state_q;
        word_d     = word_q;
        txData_d   = txData_q;
        txValid_d  = txValid_q;
        packetDone = 1'b0;
        pop        = 1'b0;

        case (state_q)
            IDLE: begin
                if (fill_q != '0) begin
                    pop       = 1'b1;
                    word_d    = headWord;
                    txData_d  = headWord[BYTE_WIDTH-1:0];
                    txValid_d = 1'b1;
                    state_d   = SEND_LO;
                end
            end
            SEND_LO: begin
                if (handshake) begin
                    txData_d = word_q[ALU_OUT_WIDTH-1:BYTE_WIDTH];
                    state_d  = SEND_HI;
                end
            end
            SEND_HI: begin
                if (handshake) begin
`ifdef ALU_SER_CHECKSUM_EN
                    txData_d = word_q[BYTE_WIDTH-1:0] ^ word_q[ALU_OUT_WIDTH-1:BYTE_WIDTH];
                    state_d  = SEND_CHK;
`else
                    packetDone = 1'b1;
`endif
                end
            end
`ifdef ALU_SER_CHECKSUM_EN
            SEND_CHK: begin
                if (handshake) begin
                    packetDone = 1'b1;
                end
            end
`endif
            default: begin
                state_d   = IDLE;
                txValid_d = 1'b0;
            end
        endcase

        // Chain straight into the next queued word so there is no idle bubble between packets.
        if (packetDone) begin
            if (fill_q != '0) begin
                pop      = 1'b1;
                word_d   = headWord;
                txData_d = headWord[BYTE_WIDTH-1:0];
                state_d  = SEND_LO;
            end else begin
                txValid_d = 1'b0;
                state_d   = IDLE;
            end
        end
    end

    assign push   = out_valid_i && ((fill_q != FW'(DEPTH)) || pop);
    assign fill_d = fill_q + FW'(push) - FW'(pop);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            wrPtr_q    <= '0;
            rdPtr_q    <= '0;
            fill_q     <= '0;
            word_q     <= '0;
            txData_q   <= '0;
            txValid_q  <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            fill_q    <= fill_d;
            word_q    <= word_d;
            txData_q  <= txData_d;
            txValid_q <= txValid_d;
            if (push) begin
                wrPtr_q <= wrPtr_q + AW'(1);
            end
            if (pop) begin
                rdPtr_q <= rdPtr_q + AW'(1);
            end
            if (out_valid_i && !push) begin
                overflow_q <= 1'b1;
            end
        end
    end

    // Storage carries no reset; entries are only ever read after being written.
    always_ff @(posedge clk_i) begin
        if (!rst_i && push) begin
            mem_q[wrPtr_q] <= alu_out_i;
        end
    end

    assign tx_data_o  = txData_q;
    assign tx_valid_o = txValid_q;
    assign fill_o     = fill_q;
    assign busy_o     = (state_q != IDLE) || (fill_q != '0);
    assign overflow_o = overflow_q;

endmodule

// File: tb/tb_alu_result_serializer.sv
// Self-checking bench for alu_result_serializer: directed scenarios plus random traffic against a queue-based reference.
// Honours ALU_SER_CHECKSUM_EN the same way as the design.
module tb_alu_result_serializer;

    localparam int DEPTH = 4;

    logic        clk;
    logic        rst;
    logic [15:0] aluOut;
    logic        outValid;
    logic [7:0]  txData;
    logic        txValid;
    logic        txReady;
    logic [2:0]  fill;
    logic        busy;
    logic        overflow;

    int checkCount;
    int passCount;

    // Reference: queued results plus the bytes still owed for the packet currently on the wire.
    logic [15:0] fifoModel [$];
    logic [7:0]  pktModel [$];
    bit          ovfModel;

    alu_result_serializer #(
        .ALU_OUT_WIDTH (16),
        .BYTE_WIDTH    (8),
        .DEPTH         (DEPTH)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .alu_out_i   (aluOut),
        .out_valid_i (outValid),
        .tx_data_o   (txData),
        .tx_valid_o  (txValid),
        .tx_ready_i  (txReady),
        .fill_o      (fill),
        .busy_o      (busy),
        .overflow_o  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s observed=%0h expected=%0h at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic modelEdge(input bit r, input bit v, input logic [15:0] d, input bit rdy);
        bit          hs;
        bit          doPop;
        bit          doPush;
        logic [15:0] w;
        if (r) begin
            fifoModel.delete();
            pktModel.delete();
            ovfModel = 1'b0;
            return;
        end
        hs     = (pktModel.size() != 0) && rdy;
        doPop  = (fifoModel.size() != 0) && ((pktModel.size() == 0) || (hs && pktModel.size() == 1));
        doPush = v && ((fifoModel.size() < DEPTH) || doPop);
        if (hs) void'(pktModel.pop_front());
        if (doPop) begin
            w = fifoModel.pop_front();
            pktModel.push_back(w[7:0]);
            pktModel.push_back(w[15:8]);
`ifdef ALU_SER_CHECKSUM_EN
            pktModel.push_back(w[7:0] ^ w[15:8]);
`endif
        end
        if (doPush) fifoModel.push_back(d);
        else if (v) ovfModel = 1'b1;
    endtask

    task automatic compareAll(input bit wasReset);
        checkOutput("txValid", 32'(txValid), 32'(pktModel.size() != 0));
        if (pktModel.size() != 0) checkOutput("txData", 32'(txData), 32'(pktModel[0]));
        else if (wasReset) checkOutput("rstTxData", 32'(txData), 32'h0);
        checkOutput("fill", 32'(fill), 32'(fifoModel.size()));
        checkOutput("busy", 32'(busy), 32'((pktModel.size() != 0) || (fifoModel.size() != 0)));
        checkOutput("overflow", 32'(overflow), 32'(ovfModel));
    endtask

    task automatic applyStimulus(input bit r, input bit v, input logic [15:0] d, input bit rdy);
        rst      = r;
        outValid = v;
        aluOut   = d;
        txReady  = rdy;
        @(posedge clk);
        modelEdge(r, v, d, rdy);
        #1;
        compareAll(r);
    endtask

    initial begin
        checkCount = 0;
        passCount  = 0;
        ovfModel   = 1'b0;
        rst = 1'b1; outValid = 1'b0; aluOut = '0; txReady = 1'b0;

        applyStimulus(1, 0, 16'h0, 0);
        applyStimulus(1, 0, 16'h0, 1);

        // Single result, free-running transmitter.
        applyStimulus(0, 1, 16'h1234, 1);
        applyStimulus(0, 0, 16'h0, 1);
        checkOutput("single lo", 32'(txData), 32'h34);
        applyStimulus(0, 0, 16'h0, 1);
        checkOutput("single hi", 32'(txData), 32'h12);
`ifdef ALU_SER_CHECKSUM_EN
        applyStimulus(0, 0, 16'h0, 1);
        checkOutput("single chk", 32'(txData), 32'h26);
`endif
        applyStimulus(0, 0, 16'h0, 1);
        checkOutput("single idle", 32'(txValid), 32'h0);

        // Backpressure holds the low byte stable.
        applyStimulus(0, 1, 16'hA55A, 0);
        for (int i = 0; i < 5; i++) applyStimulus(0, 0, 16'h0, 0);
        checkOutput("bp hold data", 32'(txData), 32'h5A);
        checkOutput("bp hold valid", 32'(txValid), 32'h1);
        for (int i = 0; i < 4; i++) applyStimulus(0, 0, 16'h0, 1);

        // Back-to-back words 1..4.
        for (int i = 1; i <= 4; i++) applyStimulus(0, 1, 16'(i), 1);
        for (int i = 0; i < 12; i++) applyStimulus(0, 0, 16'h0, 1);
        checkOutput("b2b drained", 32'(fill), 32'h0);

        // Overflow: six words against a stalled transmitter.
        for (int i = 0; i < 6; i++) applyStimulus(0, 1, 16'h0100 + 16'(i), 0);
        checkOutput("ovf fill", 32'(fill), 32'h4);
        checkOutput("ovf flag", 32'(overflow), 32'h1);
        for (int i = 0; i < 18; i++) applyStimulus(0, 0, 16'h0, 1);

        // Full FIFO with a same-edge pop accepts the new word.
        applyStimulus(1, 0, 16'h0, 0);
        for (int i = 0; i < 5; i++) applyStimulus(0, 1, 16'h2000 + 16'(i), 0);
        applyStimulus(0, 0, 16'h0, 1);
`ifdef ALU_SER_CHECKSUM_EN
        applyStimulus(0, 0, 16'h0, 1);
`endif
        applyStimulus(0, 1, 16'h2BAD, 1);
        checkOutput("fullpop fill", 32'(fill), 32'h4);
        checkOutput("fullpop ovf", 32'(overflow), 32'h0);
        for (int i = 0; i < 18; i++) applyStimulus(0, 0, 16'h0, 1);

        // Reset in the middle of a packet with two words queued.
        for (int i = 0; i < 3; i++) applyStimulus(0, 1, 16'h3000 + 16'(i), 0);
        applyStimulus(0, 0, 16'h0, 1);
        applyStimulus(1, 0, 16'h0, 0);
        checkOutput("midrst valid", 32'(txValid), 32'h0);
        checkOutput("midrst fill", 32'(fill), 32'h0);
        checkOutput("midrst busy", 32'(busy), 32'h0);
        for (int i = 0; i < 5; i++) applyStimulus(0, 0, 16'h0, 1);

        // Random traffic alternating between a mostly-ready and a mostly-stalled transmitter.
        for (int i = 0; i < 3000; i++) begin
            bit r;
            bit v;
            bit rdy;
            r   = ($urandom_range(0, 299) == 0);
            v   = ($urandom_range(0, 2) == 0);
            rdy = ((i / 400) % 2 == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
            applyStimulus(r, v, 16'($urandom), rdy);
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
